// File: rtl/pwm_capture.sv
// PWM period / high-time capture with timeout and stuck-level detection.
// Optional 3-sample majority glitch filter enabled by PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             timeout_o,
    output logic             stuck_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOCKED
    } state_t;

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic             pwm_s;
    logic             rise;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             stuck_q, stuck_d;

    assign sync_d = {sync_q[0], pwm_in};

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Registered 2-of-3 vote over the synchronized level and its two predecessors.
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;

    always_comb begin
        hist_d = {hist_q[0], sync_q[1]};
        filt_d = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign pwm_s = filt_q;
`else
    assign pwm_s = sync_q[1];
`endif

    assign prev_d = pwm_s;
    assign rise   = pwm_s & ~prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_p_d   = cnt_p_q;
        cnt_h_d   = cnt_h_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        stuck_d   = stuck_q;

        if (ena) begin
            if (rise) begin
                cnt_p_d = CNT_ONE;
                cnt_h_d = CNT_ONE;
            end else begin
                if (cnt_p_q != CNT_MAX) begin
                    cnt_p_d = cnt_p_q + CNT_ONE;
                end
                if (pwm_s && (cnt_h_q != CNT_MAX)) begin
                    cnt_h_d = cnt_h_q + CNT_ONE;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d   = ST_ARMED;
                        timeout_d = 1'b0;
                    end else if ((cnt_p_q == CNT_MAX) && !timeout_q) begin
                        // timeout_q doubles as the "already reported" flag
                        period_d  = CNT_ZERO;
                        high_d    = CNT_ZERO;
                        timeout_d = 1'b1;
                        stuck_d   = pwm_s;
                        valid_d   = 1'b1;
                    end
                end
                ST_ARMED, ST_LOCKED: begin
                    if (rise) begin
                        state_d  = ST_LOCKED;
                        period_d = cnt_p_q;
                        high_d   = cnt_h_q;
                        valid_d  = 1'b1;
                    end else if (cnt_p_q == CNT_MAX) begin
                        state_d   = ST_IDLE;
                        period_d  = CNT_ZERO;
                        high_d    = CNT_ZERO;
                        timeout_d = 1'b1;
                        stuck_d   = pwm_s;
                        valid_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b00;
            prev_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_p_q   <= CNT_ZERO;
            cnt_h_q   <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_p_q   <= cnt_p_d;
            cnt_h_q   <= cnt_h_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            stuck_q   <= stuck_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign locked_o  = (state_q == ST_LOCKED);
    assign timeout_o = timeout_q;
    assign stuck_o   = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: tests queue expected results, a monitor pops them on valid_o.
module tb_pwm_capture;

    localparam int CNT_W = 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT  = 5;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
        logic             locked;
        logic             to;
        logic             stuck;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             pwm_in;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic             locked_o;
    logic             timeout_o;
    logic             stuck_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .pwm_in    (pwm_in),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .locked_o  (locked_o),
        .timeout_o (timeout_o),
        .stuck_o   (stuck_o)
    );

    always #5 clk = ~clk;

    // Every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d locked=%0d timeout=%0d stuck=%0d, required no pulse",
                         period_o, high_o, locked_o, timeout_o, stuck_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (period_o !== mon_e.p || high_o !== mon_e.h || locked_o !== mon_e.locked ||
                    timeout_o !== mon_e.to || stuck_o !== mon_e.stuck) begin
                    errors++;
                    $display("FAIL valid_result: got period=%0d high=%0d locked=%0d timeout=%0d stuck=%0d, required period=%0d high=%0d locked=%0d timeout=%0d stuck=%0d",
                             period_o, high_o, locked_o, timeout_o, stuck_o,
                             mon_e.p, mon_e.h, mon_e.locked, mon_e.to, mon_e.stuck);
                end else begin
                    $display("valid ok: period=%0d high=%0d locked=%0d timeout=%0d stuck=%0d",
                             period_o, high_o, locked_o, timeout_o, stuck_o);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input int p, input int h, input logic l, input logic t, input logic s);
        exp_t e;
        e.p      = p[CNT_W-1:0];
        e.h      = h[CNT_W-1:0];
        e.locked = l;
        e.to     = t;
        e.stuck  = s;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v);
        pwm_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) drive_bit(v);
    endtask

    task automatic drive_period(input int p, input int h);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    // n periods; rise i>0 closes a (p,h) period, rise 0 optionally closes a (p0,h0) one.
    task automatic train(input int p, input int h, input int n, input bit push0, input int p0, input int h0);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                if (push0) push_exp(p0, h0, 1'b1, 1'b0, 1'b0);
            end else begin
                push_exp(p, h, 1'b1, 1'b0, 1'b0);
            end
            drive_period(p, h);
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        ena    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_valid: got %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            $display("%s: scoreboard drained", name);
        end
    endtask

    task automatic check_val(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ena    = 1'b1;
        pwm_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (period_o !== 8'd0)  begin errors++; $display("FAIL reset_period: got %0d, required 0", period_o); end
        if (high_o !== 8'd0)    begin errors++; $display("FAIL reset_high: got %0d, required 0", high_o); end
        if (valid_o !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %0d, required 0", valid_o); end
        if (locked_o !== 1'b0)  begin errors++; $display("FAIL reset_locked: got %0d, required 0", locked_o); end
        if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0d, required 0", timeout_o); end
        if (stuck_o !== 1'b0)   begin errors++; $display("FAIL reset_stuck: got %0d, required 0", stuck_o); end
        checks += 6;
        $display("test_reset: outputs sampled under reset");
        rst    = 1'b0;
        pwm_in = 1'b0;
        drain("test_reset");
    endtask

    task automatic test_basic();
        apply_reset();
        train(10, 3, 4, 1'b0, 0, 0);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        drive_period(10, 3);
        check_val("basic_locked", {7'd0, locked_o}, 8'd1);
        check_val("basic_period", period_o, 8'd10);
        check_val("basic_high", high_o, 8'd3);
        drain("test_basic");
    endtask

    task automatic test_latency();
        logic exp_v;
        apply_reset();
        drive_period(10, 3);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            pwm_in = (k <= 3);
            @(posedge clk);
            #1;
            exp_v = (k == LAT);
            checks++;
            if (valid_o !== exp_v) begin
                errors++;
                $display("FAIL latency_edge%0d: got valid=%0d, required %0d", k, valid_o, exp_v);
            end
        end
        hold(1'b0, 10 - LAT);
        drain("test_latency");
    endtask

    task automatic test_timeout_low();
        apply_reset();
        train(10, 3, 3, 1'b0, 0, 0);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        push_exp(0, 0, 1'b0, 1'b1, 1'b0);
        drive_period(300, 3);
        check_val("tlow_timeout", {7'd0, timeout_o}, 8'd1);
        check_val("tlow_stuck", {7'd0, stuck_o}, 8'd0);
        check_val("tlow_period", period_o, 8'd0);
        check_val("tlow_locked", {7'd0, locked_o}, 8'd0);
        drive_period(10, 3);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        drive_period(10, 3);
        check_val("tlow_relocked", {7'd0, locked_o}, 8'd1);
        check_val("tlow_timeout_cleared", {7'd0, timeout_o}, 8'd0);
        drain("test_timeout_low");
    endtask

    task automatic test_timeout_high();
        apply_reset();
        train(10, 3, 3, 1'b0, 0, 0);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        push_exp(0, 0, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 300);
        check_val("thigh_timeout", {7'd0, timeout_o}, 8'd1);
        check_val("thigh_stuck", {7'd0, stuck_o}, 8'd1);
        check_val("thigh_high", high_o, 8'd0);
        hold(1'b0, 5);
        drain("test_timeout_high");
    endtask

    task automatic test_idle_timeout();
        apply_reset();
        push_exp(0, 0, 1'b0, 1'b1, 1'b0);
        hold(1'b0, 300);
        check_val("idle_timeout", {7'd0, timeout_o}, 8'd1);
        hold(1'b0, 300);
        drive_period(10, 3);
        check_val("idle_rise_clears_timeout", {7'd0, timeout_o}, 8'd0);
        check_val("idle_rise_not_locked", {7'd0, locked_o}, 8'd0);
        drain("test_idle_timeout");
    endtask

    task automatic test_boundary();
        apply_reset();
        train(254, 100, 3, 1'b0, 0, 0);
        train(255, 100, 2, 1'b1, 254, 100);
        push_exp(255, 100, 1'b1, 1'b0, 1'b0);
        push_exp(0, 0, 1'b0, 1'b1, 1'b0);
        drive_period(260, 100);
        push_exp(0, 0, 1'b0, 1'b1, 1'b0);
        drive_period(260, 100);
        drive_bit(1'b1);
        hold(1'b0, 5);
        check_val("boundary_rearmed_timeout", {7'd0, timeout_o}, 8'd0);
        drain("test_boundary");
    endtask

    task automatic test_ena();
        bit held_ok;
        apply_reset();
        train(10, 3, 3, 1'b0, 0, 0);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        held_ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            pwm_in = (c < 3) || (c >= 6 && c < 9);
            ena    = !(c >= 5 && c < 15);
            @(posedge clk);
            #1;
            if (c >= 6 && c < 15 && (valid_o !== 1'b0 || period_o !== 8'd10 || locked_o !== 1'b1))
                held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL ena_hold: got valid=%0d period=%0d locked=%0d, required 0/10/1 frozen",
                     valid_o, period_o, locked_o);
        end
        push_exp(20, 3, 1'b1, 1'b0, 1'b0);
        drive_period(10, 3);
        drain("test_ena");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        train(10, 3, 3, 1'b0, 0, 0);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 3);
        hold(1'b0, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (period_o !== 8'd0 || high_o !== 8'd0 || valid_o !== 1'b0 || locked_o !== 1'b0 ||
            timeout_o !== 1'b0 || stuck_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got period=%0d high=%0d valid=%0d locked=%0d timeout=%0d stuck=%0d, required all 0",
                     period_o, high_o, valid_o, locked_o, timeout_o, stuck_o);
        end
        rst = 1'b0;
        drive_period(10, 3);
        check_val("midreset_not_locked", {7'd0, locked_o}, 8'd0);
        push_exp(10, 3, 1'b1, 1'b0, 1'b0);
        drive_period(10, 3);
        check_val("midreset_relocked", {7'd0, locked_o}, 8'd1);
        drain("test_reset_mid");
    endtask

    task automatic test_glitch();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                if (FILT) push_exp(20, 5, 1'b1, 1'b0, 1'b0);
                else      push_exp(10, 1, 1'b1, 1'b0, 1'b0);
            end
            hold(1'b1, 5);
            hold(1'b0, 5);
            if (!FILT) push_exp(10, 5, 1'b1, 1'b0, 1'b0);
            hold(1'b1, 1);
            hold(1'b0, 9);
        end
        if (FILT) push_exp(20, 5, 1'b1, 1'b0, 1'b0);
        else      push_exp(10, 1, 1'b1, 1'b0, 1'b0);
        drive_period(20, 5);
        drain("test_glitch");
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_latency();
        test_timeout_low();
        test_timeout_high();
        test_idle_timeout();
        test_boundary();
        test_ena();
        test_reset_mid();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of period/high counters and result outputs.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: ena  input  1  capture enable; low freezes counters, state and outputs.
REQ-005 SHALL have port: pwm_in  input  1  asynchronous PWM signal to measure.
REQ-006 SHALL have port: period_o  output  CNT_W  last measured period, rising edge to rising edge, in clk cycles.
REQ-007 SHALL have port: high_o  output  CNT_W  last measured high time, in clk cycles.
REQ-008 SHALL have port: valid_o  output  1  one-cycle pulse when period_o/high_o/timeout_o update.
REQ-009 SHALL have port: locked_o  output  1  level; a full period has been measured since the last reset/timeout.
REQ-010 SHALL have port: timeout_o  output  1  level; no rising edge within 2^CNT_W-1 cycles.
REQ-011 SHALL have port: stuck_o  output  1  synchronized pwm level captured at timeout (0 = 0% duty, 1 = 100% duty).

Function
REQ-012 SHALL synchronize pwm_in through 2 flops (pwm_s), then register pwm_s once (pwm_d); rise = pwm_s & ~pwm_d.
REQ-013 SHALL implement states IDLE, ARMED, LOCKED.
REQ-014 Rise cycle SHALL load cnt_p=1 and cnt_h=1. Other ena cycles: cnt_p+1 and cnt_h+pwm_s, both saturating at 2^CNT_W-1.
REQ-015 IDLE + rise -> ARMED, no valid_o, timeout_o cleared.
REQ-016 ARMED/LOCKED + rise -> LOCKED; period_o<=cnt_p, high_o<=cnt_h, valid_o=1 on the next cycle.
REQ-017 ARMED/LOCKED with cnt_p==2^CNT_W-1 and no rise -> IDLE; period_o<=0, high_o<=0, timeout_o<=1, stuck_o<=pwm_s, valid_o pulses once.
REQ-018 IDLE with no rise for 2^CNT_W-1 cycles after reset (cnt_p saturates) SHALL also set timeout_o/stuck_o and pulse valid_o once; no repeat pulse while still stuck.
REQ-019 Rise while cnt_p saturated SHALL be treated as rise (REQ-016), not timeout; rise has priority.
REQ-020 high_o SHALL never exceed period_o.
REQ-021 Latency: valid_o SHALL be high exactly 3 clk edges after the first clk edge sampling pwm_in high.
REQ-022 ena low SHALL hold cnt_p, cnt_h, state, outputs; valid_o=0; synchronizer and pwm_d keep running, so rises during ena low are lost.
REQ-023 locked_o SHALL equal (state==LOCKED).

Reset
REQ-024 rst SHALL force state IDLE, cnt_p=0, cnt_h=0, synchronizer and pwm_d=0, period_o=0, high_o=0, valid_o=0, locked_o=0, timeout_o=0, stuck_o=0.
REQ-025 rst mid-period SHALL discard partial counts; first valid_o after reset needs two new rises.

Configuration
REQ-026 With PWM_CAPTURE_GLITCH_FILTER_EN defined, pwm_s SHALL pass through a 3-sample majority filter (registered), adding exactly 2 cycles latency (REQ-021 becomes 5) and rejecting isolated 1-cycle pulses/dropouts.
REQ-027 Without PWM_CAPTURE_GLITCH_FILTER_EN, no filter logic SHALL exist and REQ-021 latency of 3 holds.

Verification (CNT_W=8)
REQ-028 Period 10, high 3, repeated -> after 2nd rise valid_o pulses with period_o=10, high_o=3, locked_o=1; identical on every later period.
REQ-029 pwm_in held low 300 cycles after lock -> single valid_o, timeout_o=1, stuck_o=0, period_o=0, locked_o=0; next two rises relock.
REQ-030 pwm_in held high 300 cycles -> timeout_o=1, stuck_o=1, high_o=0; single valid_o pulse.
REQ-031 Period 254 high 100 -> period_o=254, high_o=100; period 260 -> timeout, no valid measurement.
REQ-032 rst asserted 1 cycle mid-period while locked -> all outputs 0 next cycle; valid_o only after 2 further rises.
REQ-033 Period 20 with extra 1-cycle high glitch at offset 10 -> with filter: period_o=20 unaffected; without filter: period_o=10 and 10 alternately.
